// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: state encoding, default drain length and stall/flush patterns for pipeline_ctrl
package pipeline_ctrl_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_RUN      = 2'd0;
    localparam logic [STATE_W-1:0] ST_DRAIN    = 2'd1;
    localparam logic [STATE_W-1:0] ST_REDIRECT = 2'd2;
    localparam logic [STATE_W-1:0] ST_HALT     = 2'd3;

    localparam int unsigned DEFAULT_DRAIN_CYCLES = 3;

    // One bundle of the five per-stage strobes, MSB first
    typedef struct packed {
        logic fStall;
        logic dStall;
        logic eStall;
        logic dFlush;
        logic eFlush;
    } ctrlT;

    localparam ctrlT C_NONE  = 5'b00000;
    localparam ctrlT C_BUSY  = 5'b11100;  // freeze everything behind a busy stage
    localparam ctrlT C_TRAP  = 5'b10011;  // kill FD/DE, hold PC while entering drain/halt
    localparam ctrlT C_KILL  = 5'b00011;  // kill FD/DE, fetch continues from new PC
    localparam ctrlT C_HOLD  = 5'b11001;  // hold front end, feed bubbles into execute
    localparam ctrlT C_PRED  = 5'b00010;  // discard wrong-path FD only
    localparam ctrlT C_RESET = 5'b11111;

endpackage

// File: rtl/pipeline_ctrl_perf.sv
// pipeline_ctrl_perf: stall-cycle, mispredict-flush and completed-drain counters (PIPE_CTRL_PERF_CNT_EN only)
module pipeline_ctrl_perf (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        stallInc,
    input  logic        flushInc,
    input  logic        drainInc,
    output logic [31:0] stallCycles_o,
    output logic [31:0] flushEvents_o,
    output logic [15:0] drainCount_o
);

    // Free-running event counters, wrapping at their maximum
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            stallCycles_o <= '0;
            flushEvents_o <= '0;
            drainCount_o  <= '0;
        end else begin
            stallCycles_o <= stallCycles_o + 32'(stallInc);
            flushEvents_o <= flushEvents_o + 32'(flushInc);
            drainCount_o  <= drainCount_o + 16'(drainInc);
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard/flush priority encoder plus drain/halt FSM; PIPE_CTRL_PERF_CNT_EN adds perf counters
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES   = DEFAULT_DRAIN_CYCLES,
    parameter bit          HALT_ON_EBREAK = 1'b1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               dataHazard_i,
    input  logic               D_predictPC_i,
    input  logic               E_correctPC_i,
    input  logic               E_busy_i,
    input  logic               M_busy_i,
    input  logic               E_drainReq_i,
    input  logic               E_isEBREAK_i,
    input  logic               resume_i,
    output logic               F_stall_o,
    output logic               D_stall_o,
    output logic               E_stall_o,
    output logic               D_flush_o,
    output logic               E_flush_o,
    output logic               halted_o,
    output logic               drainDone_o,
    output logic [STATE_W-1:0] state_o
`ifdef PIPE_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]        stallCycles_o,
    output logic [31:0]        flushEvents_o,
    output logic [15:0]        drainCount_o
`endif
);

    // A zero-length drain still needs a 1-bit counter so the exit test stays legal
    localparam int               CNT_W    = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DRAIN_CYCLES);

    logic [STATE_W-1:0] state, nextState;
    logic [CNT_W-1:0]   drainCnt, nextCnt;
    ctrlT               ctrl;
    logic               drainDone;

    // Fixed-priority request merge in RUN and per-state strobes elsewhere
    always_comb begin
        ctrl      = C_NONE;
        nextState = state;
        nextCnt   = drainCnt;
        drainDone = 1'b0;
        case (state)
            ST_RUN: begin
                if (M_busy_i || E_busy_i) begin
                    ctrl = C_BUSY;
                end else if (E_isEBREAK_i && HALT_ON_EBREAK) begin
                    ctrl      = C_TRAP;
                    nextState = ST_HALT;
                end else if (E_drainReq_i) begin
                    ctrl      = C_TRAP;
                    nextState = ST_DRAIN;
                    nextCnt   = CNT_INIT;
                end else if (E_correctPC_i) begin
                    ctrl = C_KILL;
                end else if (dataHazard_i) begin
                    ctrl = C_HOLD;
                end else if (D_predictPC_i) begin
                    ctrl = C_PRED;
                end
            end
            ST_DRAIN: begin
                ctrl = C_HOLD;
                if (!M_busy_i) begin
                    drainDone = drainCnt <= CNT_W'(1);
                    nextState = drainDone ? ST_REDIRECT : ST_DRAIN;
                    nextCnt   = drainDone ? '0 : drainCnt - CNT_W'(1);
                end
            end
            ST_REDIRECT: begin
                ctrl      = C_KILL;
                nextState = ST_RUN;
            end
            default: begin
                ctrl      = C_HOLD;
                nextState = resume_i ? ST_REDIRECT : ST_HALT;
            end
        endcase
    end

    // State and drain counter; reset aborts any drain or halt back to RUN
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state    <= ST_RUN;
            drainCnt <= '0;
        end else begin
            state    <= nextState;
            drainCnt <= nextCnt;
        end
    end

    assign {F_stall_o, D_stall_o, E_stall_o, D_flush_o, E_flush_o} = reset_i ? ctrl : C_RESET;
    assign halted_o    = reset_i && state == ST_HALT;
    assign drainDone_o = reset_i && drainDone;
    assign state_o     = state;

`ifdef PIPE_CTRL_PERF_CNT_EN
    pipeline_ctrl_perf uPerf (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .stallInc      (reset_i && state == ST_RUN && ctrl.fStall),
        .flushInc      (reset_i && state == ST_RUN && ctrl == C_KILL),
        .drainInc      (drainDone_o),
        .stallCycles_o (stallCycles_o),
        .flushEvents_o (flushEvents_o),
        .drainCount_o  (drainCount_o)
    );
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed test-plan steps then random stimulus, checked against a behavioural model
module tb_pipeline_ctrl;

    logic clk_i = 1'b0;
    logic reset_i = 1'b0;
    logic dataHazard_i = 1'b0, D_predictPC_i = 1'b0, E_correctPC_i = 1'b0, E_busy_i = 1'b0;
    logic M_busy_i = 1'b0, E_drainReq_i = 1'b0, E_isEBREAK_i = 1'b0, resume_i = 1'b0;
    logic F_stall_o, D_stall_o, E_stall_o, D_flush_o, E_flush_o, halted_o, drainDone_o;
    logic [1:0] state_o;
`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [31:0] stallCycles_o, flushEvents_o;
    logic [15:0] drainCount_o;
`endif

    int nAssert = 0;
    int nFail = 0;

    typedef enum int {M_RUN = 0, M_DRAIN = 1, M_REDIR = 2, M_HALT = 3} modeT;
    modeT mode = M_RUN;
    int idleLeft = 0;
    int expStall = 0, expFlush = 0, expDrains = 0;

    always #5 clk_i = ~clk_i;

    pipeline_ctrl #(.DRAIN_CYCLES(3), .HALT_ON_EBREAK(1'b1)) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .dataHazard_i  (dataHazard_i),
        .D_predictPC_i (D_predictPC_i),
        .E_correctPC_i (E_correctPC_i),
        .E_busy_i      (E_busy_i),
        .M_busy_i      (M_busy_i),
        .E_drainReq_i  (E_drainReq_i),
        .E_isEBREAK_i  (E_isEBREAK_i),
        .resume_i      (resume_i),
        .F_stall_o     (F_stall_o),
        .D_stall_o     (D_stall_o),
        .E_stall_o     (E_stall_o),
        .D_flush_o     (D_flush_o),
        .E_flush_o     (E_flush_o),
        .halted_o      (halted_o),
        .drainDone_o   (drainDone_o),
        .state_o       (state_o)
`ifdef PIPE_CTRL_PERF_CNT_EN
        ,
        .stallCycles_o (stallCycles_o),
        .flushEvents_o (flushEvents_o),
        .drainCount_o  (drainCount_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nAssert++;
        assert (got === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected {F_stall, D_stall, E_stall, D_flush, E_flush, halted, drainDone} for current inputs
    function automatic logic [6:0] expOut();
        if (!reset_i) return 7'b1111100;
        case (mode)
            M_DRAIN: return {6'b110010, !M_busy_i && idleLeft <= 1};
            M_REDIR: return 7'b0001100;
            M_HALT:  return 7'b1100110;
            default: begin
                if (M_busy_i || E_busy_i) return 7'b1110000;
                if (E_isEBREAK_i || E_drainReq_i) return 7'b1001100;
                if (E_correctPC_i) return 7'b0001100;
                if (dataHazard_i) return 7'b1100100;
                if (D_predictPC_i) return 7'b0001000;
                return 7'b0000000;
            end
        endcase
    endfunction

    // Advance the model across one rising edge using the inputs held through it
    task automatic advance(input logic [6:0] e);
        if (!reset_i) begin
            mode = M_RUN;
            idleLeft = 0;
            expStall = 0;
            expFlush = 0;
            expDrains = 0;
        end else begin
            if (mode == M_RUN && e[6]) expStall++;
            if (mode == M_RUN && !M_busy_i && !E_busy_i && !E_isEBREAK_i && !E_drainReq_i && E_correctPC_i) expFlush++;
            if (e[0]) expDrains++;
            case (mode)
                M_RUN: if (!M_busy_i && !E_busy_i) begin
                    if (E_isEBREAK_i) mode = M_HALT;
                    else if (E_drainReq_i) begin
                        mode = M_DRAIN;
                        idleLeft = 3;
                    end
                end
                M_DRAIN: if (!M_busy_i) begin
                    if (idleLeft <= 1) mode = M_REDIR;
                    else idleLeft--;
                end
                M_REDIR: mode = M_RUN;
                default: if (resume_i) mode = M_REDIR;
            endcase
        end
    endtask

    task automatic step(input string tag);
        logic [6:0] e;
        #1;
        e = expOut();
        check({tag, ".out"}, 32'({F_stall_o, D_stall_o, E_stall_o, D_flush_o, E_flush_o, halted_o, drainDone_o}), 32'(e));
        check({tag, ".state"}, 32'(state_o), 32'(mode));
`ifdef PIPE_CTRL_PERF_CNT_EN
        check({tag, ".stallCycles"}, stallCycles_o, 32'(expStall));
        check({tag, ".flushEvents"}, flushEvents_o, 32'(expFlush));
        check({tag, ".drainCount"}, 32'(drainCount_o), 32'(expDrains));
`endif
        @(posedge clk_i);
        advance(e);
        #1;
    endtask

    task automatic idle();
        reset_i = 1'b1;
        {dataHazard_i, D_predictPC_i, E_correctPC_i, E_busy_i, M_busy_i, E_drainReq_i, E_isEBREAK_i, resume_i} = '0;
    endtask

    initial begin
        int drainSeen;
        int doneSeen;
        // Reset held for two cycles, then idle
        step("rst0");
        step("rst1");
        idle();
        step("idle");
        check("idle.quiet", 32'({F_stall_o, D_stall_o, E_stall_o, D_flush_o, E_flush_o}), 32'd0);
        // Load-use hazard masks a prediction, which then applies alone
        dataHazard_i = 1'b1;
        D_predictPC_i = 1'b1;
        step("ldu");
        dataHazard_i = 1'b0;
        step("pred");
        // Mispredict beats a hazard; a busy memory stage beats both
        idle();
        E_correctPC_i = 1'b1;
        dataHazard_i = 1'b1;
        step("misp");
        M_busy_i = 1'b1;
        step("mispBusy");
        // Drain with bus wait on drain cycles 2-3
        idle();
        E_drainReq_i = 1'b1;
        step("drReq");
        E_drainReq_i = 1'b0;
        drainSeen = 0;
        doneSeen = 0;
        for (int i = 1; i <= 7; i++) begin
            M_busy_i = (i == 2 || i == 3);
            #1;
            if (state_o == 2'd1) drainSeen++;
            if (drainDone_o) doneSeen++;
            step("drain");
        end
        check("drain.cycles", 32'(drainSeen), 32'd5);
        check("drain.donePulses", 32'(doneSeen), 32'd1);
        // EBREAK beats drain, then halt until resume
        idle();
        E_isEBREAK_i = 1'b1;
        E_drainReq_i = 1'b1;
        step("brk");
        idle();
        for (int i = 0; i < 10; i++) step("halt");
        check("halt.flag", 32'(halted_o), 32'd1);
        resume_i = 1'b1;
        step("resume");
        resume_i = 1'b0;
        step("hRedir");
        step("hRun");
        // Reset while halted returns to RUN
        E_isEBREAK_i = 1'b1;
        step("brk2");
        E_isEBREAK_i = 1'b0;
        step("halt2");
        reset_i = 1'b0;
        step("hRst");
        idle();
        step("postRst");
        check("postRst.state", 32'(state_o), 32'd0);
`ifdef PIPE_CTRL_PERF_CNT_EN
        reset_i = 1'b0;
        step("pRst");
        idle();
        dataHazard_i = 1'b1;
        for (int i = 0; i < 4; i++) step("pHaz");
        idle();
        E_correctPC_i = 1'b1;
        for (int i = 0; i < 2; i++) step("pMisp");
        idle();
        #1;
        check("perf.stall4", stallCycles_o, 32'd4);
        check("perf.flush2", flushEvents_o, 32'd2);
        step("pIdle");
`endif
        // Random traffic with biased request rates
        for (int i = 0; i < 3000; i++) begin
            reset_i = $urandom_range(0, 99) != 0;
            M_busy_i = $urandom_range(0, 99) < 15;
            E_busy_i = $urandom_range(0, 99) < 10;
            E_isEBREAK_i = $urandom_range(0, 99) < 5;
            E_drainReq_i = $urandom_range(0, 99) < 8;
            E_correctPC_i = $urandom_range(0, 99) < 20;
            dataHazard_i = $urandom_range(0, 99) < 30;
            D_predictPC_i = $urandom_range(0, 99) < 30;
            resume_i = $urandom_range(0, 99) < 20;
            step("rand");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central hazard and flush scheduler for the 5-stage RV32 pipeline. Merges stall and redirect requests from the decode, execute and memory stages into per-stage stall and flush strobes by fixed priority. Sequences multi-cycle pipeline drains for FENCE/FENCE.I and the EBREAK debug halt.
Sits beside the datapath; its outputs drive D_stall_i, D_flush_i, E_flush_i and E_stall_i of the decode unit, plus the fetch unit's stall.

Parameters:
DRAIN_CYCLES, 3, cycles with M_busy_i low needed to empty E/M/W after a drain request
HALT_ON_EBREAK, 1, 1 = EBREAK enters HALT; 0 = EBREAK is treated as NOP by this block

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous, active-low reset
dataHazard_i  in  1  decode load-use / CSR / AMO hazard
D_predictPC_i  in  1  decode redirected fetch (predicted jump/branch)
E_correctPC_i  in  1  execute mispredict; fetch redirected to corrected PC
E_busy_i  in  1  multi-cycle DIV/FPU op occupying execute
M_busy_i  in  1  memory stage waiting on bus
E_drainReq_i  in  1  FENCE/FENCE.I in execute
E_isEBREAK_i  in  1  EBREAK in execute
resume_i  in  1  debug resume pulse
F_stall_o  out  1  hold PC / FD register
D_stall_o  out  1  hold DE register
E_stall_o  out  1  hold execute and EM register
D_flush_o  out  1  kill instruction in FD
E_flush_o  out  1  insert bubble in DE
halted_o  out  1  core halted
drainDone_o  out  1  one-cycle pulse when a drain completes
state_o  out  2  current FSM state, for debug

Behaviour:
- State register is the only sequential element besides drainCnt[$clog2(DRAIN_CYCLES+1)-1:0]. Outputs are combinational from state and inputs.
- While reset_i=0:
  - F_stall, D_stall, E_stall, D_flush, E_flush all = 1; halted=0; drainDone=0.
  - Next state RUN, drainCnt=0.
  - Reset mid-DRAIN or mid-HALT aborts to RUN.
- States: RUN=0, DRAIN=1, REDIRECT=2, HALT=3.
- RUN priority, highest first; only the first matching row applies:
  1. M_busy_i: F, D and E stall; no flush.
  2. E_busy_i: F, D and E stall; no flush.
  3. E_isEBREAK_i & HALT_ON_EBREAK: D_flush=1, E_flush=1, F_stall=1; next HALT.
  4. E_drainReq_i: D_flush=1, E_flush=1, F_stall=1; drainCnt<=DRAIN_CYCLES; next DRAIN.
  5. E_correctPC_i: D_flush=1, E_flush=1; no stall. Any pending dataHazard or prediction is discarded.
  6. dataHazard_i: F_stall=1, D_stall=1, E_flush=1 (one bubble). D_predictPC_i is ignored this cycle and re-evaluated next cycle.
  7. D_predictPC_i: D_flush=1 (discard wrong-path FD).
  8. Otherwise: all outputs 0.
- Simultaneous events: EBREAK beats drain; drain beats mispredict. A busy input in the same cycle defers all of rows 3-7, since the execute instruction is not yet retiring.
- DRAIN:
  - F_stall=1, D_stall=1, E_flush=1 every cycle.
  - drainCnt decrements when M_busy_i=0 and holds otherwise.
  - When drainCnt==1 and M_busy_i=0: drainDone_o=1 this cycle; next REDIRECT.
  - With DRAIN_CYCLES=0, exit on the first cycle with M_busy_i=0.
- REDIRECT (exactly 1 cycle):
  - D_flush=1, E_flush=1; F_stall=0, so fetch restarts at the PC it already holds.
  - Next RUN. All inputs are ignored this cycle.
- HALT:
  - F_stall=1, D_stall=1, E_flush=1; halted_o=1.
  - resume_i=1 moves to REDIRECT; otherwise stay.
  - resume_i while not in HALT is ignored.
- halted_o=1 only in HALT. state_o reflects the registered state.

Optional Feature:
Macro PIPE_CTRL_PERF_CNT_EN.
- Defined: adds outputs stallCycles_o[31:0], flushEvents_o[31:0] and drainCount_o[15:0], all reset to 0 and wrapping at max.
  - stallCycles_o increments on each cycle with F_stall_o=1 in RUN.
  - flushEvents_o increments on each cycle with E_correctPC_i acted on (row 5).
  - drainCount_o increments on each drainDone_o.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package pipeline_ctrl_pkg holds:
  - the state encoding localparams (ST_RUN, ST_DRAIN, ST_REDIRECT, ST_HALT);
  - the default DRAIN_CYCLES constant;
  - the width of state_o.
- Sub-module pipeline_ctrl_perf holds the three counters and is instantiated only under PIPE_CTRL_PERF_CNT_EN.
- Priority encoder and FSM stay in one module.

Test Plan:
- Reset: reset_i=0 for 2 cycles → all stall/flush=1, state_o=0. Release → outputs 0 with idle inputs.
- Load-use: dataHazard_i=1 and D_predictPC_i=1 for 1 cycle → F_stall=D_stall=E_flush=1, D_flush=0. Next cycle D_predictPC_i alone → D_flush=1 only.
- Mispredict with hazard: E_correctPC_i=1, dataHazard_i=1 → D_flush=E_flush=1, F_stall=0. Same stimulus with M_busy_i=1 → F, D and E stall, no flush.
- Drain with bus wait: DRAIN_CYCLES=3, E_drainReq_i pulse, M_busy_i=1 for cycles 2-3 → state DRAIN for 5 cycles, drainDone_o pulses once, 1 REDIRECT cycle, then RUN.
- Halt/resume: E_isEBREAK_i with E_drainReq_i → HALT, halted_o=1. Hold 10 cycles; resume_i pulse → REDIRECT then RUN. Reset asserted in HALT → RUN next cycle.
- Perf (macro on): 4 hazard cycles and 2 mispredicts → stallCycles_o=4, flushEvents_o=2.
